// File: rtl/rr_arb2_hold.sv
// ---------------------------------------------------------------------------
// rr_arb2_hold
//
// Two-requester round-robin arbiter with a bounded grant hold.
//
// The current owner keeps the grant for as long as it requests it. If the other
// side is also requesting, the owner loses the grant after MAX_HOLD consecutive
// cycles. Every change of owner goes through at least one idle cycle
// (gnt == 2'b00). Because of this, gnt is one-hot or zero on every cycle.
// All outputs come straight from flops.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles under contention (1..255)
//   CW        hold-counter width, derived from MAX_HOLD; do not override
//
// Ports:
//   clk      clock, all logic on the rising edge
//   rst_n    synchronous active-low reset
//   req      level-sensitive requests, bit 0 = requester 0, bit 1 = requester 1
//   gnt      one-hot grant, or 2'b00 when nobody owns the resource
//   gnt_id   index of the current owner; holds its last value while gnt == 0
//   busy     high whenever any grant is active
//   preempt  one-cycle pulse in the idle cycle that follows a forced removal
// ---------------------------------------------------------------------------
module rr_arb2_hold #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [CW-1:0] MaxHoldC = CW'(MAX_HOLD);
    localparam logic [CW-1:0] OneC     = CW'(1);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic          preempt_q, preempt_d;
    logic          owner;
    logic          winner;

    // Register process: the FSM state, the round-robin memory, the hold
    // counter and the registered outputs all reset together. A reset that
    // arrives mid-grant therefore leaves no partial state behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            gnt_q      <= 2'b00;
            gnt_id_q   <= 1'b0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
        end
    end

    // Next-state process. On a tie, the requester that was not served last
    // wins. An owner is checked for release first, then for pre-emption.
    // As a result, an owner that drops its request at the limit is released
    // normally and no preempt pulse is produced. There is no OWN0 <-> OWN1
    // arc, so every handover passes through IDLE.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        winner     = 1'b0;
        owner      = (state_q == OWN1);

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    winner     = (req == 2'b11) ? ~last_q : req[1];
                    state_d    = winner ? OWN1 : OWN0;
                    hold_cnt_d = OneC;
                end
            end
            OWN0, OWN1: begin
                if (!req[owner]) begin
                    state_d = IDLE;
                    last_d  = owner;
                end else if ((hold_cnt_q == MaxHoldC) && req[~owner]) begin
                    state_d   = IDLE;
                    last_d    = owner;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != MaxHoldC) begin
                    hold_cnt_d = hold_cnt_q + OneC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output process: decodes the next state into the next register values.
    // The outputs then change on the same edge as the state. gnt_id is left
    // untouched while idle, so it keeps showing the most recent owner.
    always_comb begin
        gnt_d    = 2'b00;
        gnt_id_d = gnt_id_q;

        case (state_d)
            OWN0: begin
                gnt_d    = 2'b01;
                gnt_id_d = 1'b0;
            end
            OWN1: begin
                gnt_d    = 2'b10;
                gnt_id_d = 1'b1;
            end
            default: begin
                gnt_d    = 2'b00;
            end
        endcase

        busy_d = |gnt_d;
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
